// File: rtl/spi_flash_reader.sv
// SPI mode-0 READ (0x03) master for the external serial flash.
// Streams 1..256 received bytes out on a valid/ready byte port.
module spi_flash_reader #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] addr,
  input  logic [7:0]  len,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    DATA,
    HOLD,
    FINISH
  } state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic [4:0]    bit_cnt;
  logic [7:0]    byte_cnt;
  logic [31:0]   shreg;
  logic [7:0]    rx;

  logic half_end;
  logic drain;
  logic last_byte;

  // Divider terminal count, output-slot free, final-byte flag.
  always_comb begin
    half_end  = (div_cnt == DIV_LAST);
    drain     = !rd_valid || rd_ready;
    last_byte = (byte_cnt == 8'd1);
  end

  // Transaction FSM; every output is a register here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      shreg    <= '0;
      rx       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
    end else begin
      if (rd_valid && rd_ready) begin
        rd_valid <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          // done still high means the previous job just ended
          if (start && !done) begin
            state    <= CMD;
            busy     <= 1'b1;
            byte_cnt <= len;
            shreg    <= {7'h03, addr, 1'b0};
            spi_mosi <= 1'b0;
            spi_cs_n <= 1'b0;
            spi_sclk <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
          end
        end
        CMD: begin
          if (half_end) begin
            div_cnt <= '0;
            if (!spi_sclk) begin
              spi_sclk <= 1'b1;
            end else begin
              spi_sclk <= 1'b0;
              if (bit_cnt == 5'd31) begin
                bit_cnt  <= '0;
                spi_mosi <= 1'b0;
                state    <= DATA;
              end else begin
                bit_cnt  <= bit_cnt + 5'd1;
                spi_mosi <= shreg[31];
                shreg    <= {shreg[30:0], 1'b0};
              end
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        DATA: begin
          if (half_end) begin
            div_cnt <= '0;
            if (!spi_sclk) begin
              spi_sclk <= 1'b1;
              rx       <= {rx[6:0], spi_miso};
            end else begin
              spi_sclk <= 1'b0;
              if (bit_cnt != 5'd7) begin
                bit_cnt <= bit_cnt + 5'd1;
              end else begin
                bit_cnt <= '0;
                if (drain) begin
                  rd_data  <= rx;
                  rd_valid <= 1'b1;
                  byte_cnt <= byte_cnt - 8'd1;
                  if (last_byte) begin
                    spi_cs_n <= 1'b1;
                    state    <= FINISH;
                  end
                end else begin
                  state <= HOLD;
                end
              end
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        HOLD: begin
          // rd_valid is known high here, so ready alone drains it
          if (rd_ready) begin
            rd_data  <= rx;
            rd_valid <= 1'b1;
            byte_cnt <= byte_cnt - 8'd1;
            div_cnt  <= '0;
            if (last_byte) begin
              spi_cs_n <= 1'b1;
              state    <= FINISH;
            end else begin
              state <= DATA;
            end
          end
        end
        FINISH: begin
          if (rd_valid && rd_ready) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader.
// Two instances: CLK_DIV=2 and CLK_DIV=1, each with a flash model.
module tb_spi_flash_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start_a = 1'b0;
  logic [23:0] addr_a = '0;
  logic [7:0]  len_a = '0;
  logic        rd_ready_a = 1'b0;
  logic        busy_a, done_a, rd_valid_a;
  logic [7:0]  rd_data_a;
  logic        cs_a, sclk_a, mosi_a;
  logic        miso_a = 1'b0;

  logic        start_b = 1'b0;
  logic [23:0] addr_b = '0;
  logic [7:0]  len_b = '0;
  logic        rd_ready_b = 1'b0;
  logic        busy_b, done_b, rd_valid_b;
  logic [7:0]  rd_data_b;
  logic        cs_b, sclk_b, mosi_b;
  logic        miso_b = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [7:0]  mem_a [256];
  logic [7:0]  mem_b [256];
  int          re_a = 0, re_b = 0, idx_a = 0, idx_b = 0;
  logic [31:0] hdr_a = '0, hdr_b = '0;
  logic        pcs_a = 1'b1, psclk_a = 1'b0;
  logic        pcs_b = 1'b1, psclk_b = 1'b0;

  spi_flash_reader #(.CLK_DIV(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .addr(addr_a), .len(len_a), .busy(busy_a),
    .done(done_a), .rd_data(rd_data_a),
    .rd_valid(rd_valid_a), .rd_ready(rd_ready_a),
    .spi_cs_n(cs_a), .spi_sclk(sclk_a),
    .spi_mosi(mosi_a), .spi_miso(miso_a)
  );

  spi_flash_reader #(.CLK_DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .addr(addr_b), .len(len_b), .busy(busy_b),
    .done(done_b), .rd_data(rd_data_b),
    .rd_valid(rd_valid_b), .rd_ready(rd_ready_b),
    .spi_cs_n(cs_b), .spi_sclk(sclk_b),
    .spi_mosi(mosi_b), .spi_miso(miso_b)
  );

  always #5 clk = ~clk;

  // Flash A: capture header on rises, drive data after falls
  always @(negedge clk) begin
    if (pcs_a && !cs_a) begin
      re_a = 0;
      hdr_a = '0;
    end
    if (!cs_a && !psclk_a && sclk_a) begin
      if (re_a < 32) hdr_a = {hdr_a[30:0], mosi_a};
      re_a++;
    end
    if (!cs_a && psclk_a && !sclk_a && re_a >= 32) begin
      idx_a = re_a - 32;
      if (idx_a < 2048) miso_a = mem_a[idx_a/8][7-(idx_a%8)];
    end
    pcs_a = cs_a;
    psclk_a = sclk_a;
  end

  // Flash B: same model for the CLK_DIV=1 instance
  always @(negedge clk) begin
    if (pcs_b && !cs_b) begin
      re_b = 0;
      hdr_b = '0;
    end
    if (!cs_b && !psclk_b && sclk_b) begin
      if (re_b < 32) hdr_b = {hdr_b[30:0], mosi_b};
      re_b++;
    end
    if (!cs_b && psclk_b && !sclk_b && re_b >= 32) begin
      idx_b = re_b - 32;
      if (idx_b < 2048) miso_b = mem_b[idx_b/8][7-(idx_b%8)];
    end
    pcs_b = cs_b;
    psclk_b = sclk_b;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go_a(input logic [23:0] a,
                      input logic [7:0] l);
    addr_a = a;
    len_a = l;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    cyc = 1;
  endtask

  task automatic go_b(input logic [23:0] a,
                      input logic [7:0] l);
    addr_b = a;
    len_b = l;
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    cyc = 1;
  endtask

  initial begin
    int n, nd, hi, t_r1, t_r2, t_v1, t_v2;
    logic ok, okh, prev;
    logic [23:0] got;
    logic [15:0] got2;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst cs_n", cs_a, 1);
    chk("rst sclk", sclk_a, 0);
    chk("rst mosi", mosi_a, 0);
    chk("rst busy", busy_a, 0);
    chk("rst done", done_a, 0);
    chk("rst rd_valid", rd_valid_a, 0);
    chk("rst rd_data", rd_data_a, 0);
    rst_n = 1'b1;
    tick();

    // single byte
    mem_a[0] = 8'hA5;
    rd_ready_a = 1'b1;
    go_a(24'h123456, 8'd1);
    chk("t1 cs low c1", cs_a, 0);
    chk("t1 busy c1", busy_a, 1);
    chk("t1 mosi c1", mosi_a, 0);
    while (!rd_valid_a && cyc < 1000) tick();
    chk("t1 valid cycle", cyc, 161);
    chk("t1 data", rd_data_a, 8'hA5);
    chk("t1 cs high", cs_a, 1);
    tick();
    chk("t1 done", done_a, 1);
    chk("t1 valid drop", rd_valid_a, 0);
    chk("t1 header", hdr_a, 32'h03123456);
    chk("t1 rises", re_a, 40);
    tick();
    chk("t1 done pulse", done_a, 0);
    chk("t1 busy low", busy_a, 0);

    // backpressure
    mem_a[0] = 8'h11;
    mem_a[1] = 8'h22;
    mem_a[2] = 8'h33;
    rd_ready_a = 1'b0;
    go_a(24'h000100, 8'd3);
    while (!rd_valid_a && cyc < 1000) tick();
    chk("bp first valid", cyc, 161);
    ok = 1'b1;
    okh = 1'b1;
    repeat (50) begin
      tick();
      if (rd_data_a !== 8'h11 || rd_valid_a !== 1'b1)
        ok = 1'b0;
      if (cyc > 194 && (sclk_a !== 1'b0 || cs_a !== 1'b0))
        okh = 1'b0;
    end
    chk("bp data held", ok, 1);
    chk("bp sclk/cs hold", okh, 1);
    chk("bp rises in hold", re_a, 48);
    rd_ready_a = 1'b1;
    n = 0;
    got = '0;
    while (!done_a && cyc < 2000) begin
      if (rd_valid_a) begin
        got = {got[15:0], rd_data_a};
        n++;
      end
      tick();
    end
    chk("bp done", done_a, 1);
    chk("bp count", n, 3);
    chk("bp bytes", got, 24'h112233);
    chk("bp rises", re_a, 56);
    tick();

    // full length
    for (int i = 0; i < 256; i++) mem_a[i] = 8'(i);
    go_a(24'h000000, 8'd0);
    n = 0;
    ok = 1'b1;
    while (!done_a && cyc < 20000) begin
      if (rd_valid_a) begin
        if (rd_data_a !== n[7:0]) ok = 1'b0;
        n++;
      end
      tick();
    end
    nd = done_a ? 1 : 0;
    repeat (5) begin
      tick();
      if (done_a) nd++;
    end
    chk("full count", n, 256);
    chk("full order", ok, 1);
    chk("full done once", nd, 1);
    chk("full rises", re_a, 2080);

    // start while busy
    mem_a[0] = 8'h5A;
    go_a(24'hC0FFEE, 8'd1);
    while (cyc < 50) tick();
    addr_a = 24'h777777;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    hi = 0;
    while (1) begin
      if (cs_a) hi++;
      else hi = 0;
      if (done_a || cyc >= 1000) break;
      tick();
    end
    chk("sb done cycle", cyc, 162);
    chk("sb header", hdr_a, 32'h03C0FFEE);
    mem_a[0] = 8'h96;
    addr_a = 24'h654321;
    start_a = 1'b1;
    tick();
    chk("sb ignored busy", busy_a, 0);
    chk("sb ignored cs", cs_a, 1);
    if (cs_a) hi++;
    chk("sb cs high cycles", hi, 3);
    tick();
    start_a = 1'b0;
    cyc = 1;
    chk("sb new cs", cs_a, 0);
    chk("sb new busy", busy_a, 1);
    while (!rd_valid_a && cyc < 1000) tick();
    chk("sb new valid", cyc, 161);
    chk("sb new data", rd_data_a, 8'h96);
    chk("sb new header", hdr_a, 32'h03654321);
    while (!done_a && cyc < 1000) tick();
    tick();

    // reset during address phase
    go_a(24'h0F0F0F, 8'd1);
    while (!(sclk_a === 1'b1 && cyc > 70) && cyc < 1000)
      tick();
    chk("ar in addr", sclk_a, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar cs_n", cs_a, 1);
    chk("ar sclk", sclk_a, 0);
    chk("ar busy", busy_a, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("ar idle cs", cs_a, 1);
    chk("ar idle busy", busy_a, 0);

    // CLK_DIV = 1
    mem_b[0] = 8'h3C;
    mem_b[1] = 8'hC3;
    rd_ready_b = 1'b1;
    go_b(24'hABCDEF, 8'd2);
    prev = 1'b0;
    t_r1 = 0;
    t_r2 = 0;
    t_v1 = 0;
    t_v2 = 0;
    n = 0;
    got2 = '0;
    while (!done_b && cyc < 1000) begin
      if (sclk_b && !prev) begin
        if (t_r1 == 0) t_r1 = cyc;
        else if (t_r2 == 0) t_r2 = cyc;
      end
      prev = sclk_b;
      if (rd_valid_b) begin
        if (n == 0) t_v1 = cyc;
        else t_v2 = cyc;
        got2 = {got2[7:0], rd_data_b};
        n++;
      end
      tick();
    end
    chk("d1 first rise", t_r1, 2);
    chk("d1 period", t_r2 - t_r1, 2);
    chk("d1 byte1 valid", t_v1, 81);
    chk("d1 byte2 valid", t_v2, 97);
    chk("d1 bytes", got2, 16'h3CC3);
    chk("d1 header", hdr_b, 32'h03ABCDEF);
    chk("d1 rises", re_b, 48);
    chk("d1 done", done_b, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
